ip_yuv444to422: RTL and testbench

IP_YUV444TO422 -- requirements
Module: ip_yuv444to422

---
 rtl/ip_yuv444to422_if.sv | 28 ++
 rtl/ip_yuv444to422.sv | 212 +++++++++++++++++++++
 tb/tb_ip_yuv444to422.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_yuv444to422_if.sv
// Pixel stream interface for the 4:4:4 to 4:2:2 converter: 4:4:4 input side and 4:2:2 output side.
interface ip_yuv444to422_if #(
  parameter int unsigned DAT_SZ = 8
);
  logic              i_vld;
  logic              i_hstr;
  logic [DAT_SZ-1:0] i_data_y;
  logic [DAT_SZ-1:0] i_data_cb;
  logic [DAT_SZ-1:0] i_data_cr;
  logic              o_rdy;
  logic              i_rdy;
  logic              o_vld;
  logic              o_hstr;
  logic [DAT_SZ-1:0] o_data_y;
  logic [DAT_SZ-1:0] o_data_c;
  logic              o_c_sel;
  logic              o_odd_err;

  modport slave (
    input  i_vld, i_hstr, i_data_y, i_data_cb, i_data_cr, i_rdy,
    output o_rdy, o_vld, o_hstr, o_data_y, o_data_c, o_c_sel, o_odd_err
  );

  modport master (
    output i_vld, i_hstr, i_data_y, i_data_cb, i_data_cr, i_rdy,
    input  o_rdy, o_vld, o_hstr, o_data_y, o_data_c, o_c_sel, o_odd_err
  );
endinterface

// File: rtl/ip_yuv444to422.sv
// 4:4:4 to 4:2:2 chroma subsampler emitting Y0/Cb, Y1/Cr words per pixel pair.
// Define IP_YUV422_FIR_EN for the 3-tap (1,2,1) chroma filter instead of the 2-tap average.
module ip_yuv444to422 #(
  parameter int unsigned DAT_SZ = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ip_yuv444to422_if.slave         bus
);

  localparam int unsigned W1 = DAT_SZ + 1;
  localparam int unsigned W2 = DAT_SZ + 2;

  typedef enum logic [1:0] {
    S_EVEN = 2'd0,
    S_ODD  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DAT_SZ-1:0] hold_y_q, hold_y_d;
  logic [DAT_SZ-1:0] hold_cb_q, hold_cb_d;
  logic [DAT_SZ-1:0] hold_cr_q, hold_cr_d;
  logic              hold_hstr_q, hold_hstr_d;
  logic              o_vld_q, o_vld_d;
  logic              o_hstr_q, o_hstr_d;
  logic [DAT_SZ-1:0] o_y_q, o_y_d;
  logic [DAT_SZ-1:0] o_c_q, o_c_d;
  logic              o_sel_q, o_sel_d;
  logic              err_q, err_d;

  logic              rdy_c;
  logic              in_xfer_c;
  logic              out_xfer_c;
  logic [DAT_SZ-1:0] pair_cb_c;
  logic [DAT_SZ-1:0] pair_cr_c;

`ifdef IP_YUV422_FIR_EN
  logic              hist_vld_q, hist_vld_d;
  logic [DAT_SZ-1:0] hist_cb_q, hist_cb_d;
  logic [DAT_SZ-1:0] hist_cr_q, hist_cr_d;

  function automatic logic [DAT_SZ-1:0] fir3(input logic [DAT_SZ-1:0] cp,
                                             input logic [DAT_SZ-1:0] c0,
                                             input logic [DAT_SZ-1:0] c1);
    logic [W2-1:0] s;
    s = W2'(cp) + (W2'(c0) << 1) + W2'(c1) + W2'(2);
    return s[W2-1:2];
  endfunction

  // First pair of a line has no previous odd pixel, so the even sample stands in.
  always_comb begin
    pair_cb_c = fir3(hist_vld_q ? hist_cb_q : hold_cb_q, hold_cb_q, bus.i_data_cb);
    pair_cr_c = fir3(hist_vld_q ? hist_cr_q : hold_cr_q, hold_cr_q, bus.i_data_cr);
  end
`else
  function automatic logic [DAT_SZ-1:0] avg2(input logic [DAT_SZ-1:0] a,
                                             input logic [DAT_SZ-1:0] b);
    logic [W1-1:0] s;
    s = W1'(a) + W1'(b) + W1'(1);
    return s[W1-1:1];
  endfunction

  always_comb begin
    pair_cb_c = avg2(hold_cb_q, bus.i_data_cb);
    pair_cr_c = avg2(hold_cr_q, bus.i_data_cr);
  end
`endif

  // Acceptance depends on whether the output register can take a new word.
  always_comb begin
    rdy_c = 1'b0;
    case (state_q)
      S_EVEN:  rdy_c = 1'b1;
      S_ODD:   rdy_c = ~o_vld_q | bus.i_rdy;
      S_EMIT:  rdy_c = bus.i_rdy;
      default: rdy_c = 1'b0;
    endcase
    if (rst) rdy_c = 1'b0;
  end

  assign in_xfer_c  = bus.i_vld & rdy_c;
  assign out_xfer_c = o_vld_q & bus.i_rdy;

  always_comb begin
    logic store_even;
    state_d     = state_q;
    hold_y_d    = hold_y_q;
    hold_cb_d   = hold_cb_q;
    hold_cr_d   = hold_cr_q;
    hold_hstr_d = hold_hstr_q;
    o_vld_d     = o_vld_q;
    o_hstr_d    = o_hstr_q;
    o_y_d       = o_y_q;
    o_c_d       = o_c_q;
    o_sel_d     = o_sel_q;
    err_d       = err_q;
`ifdef IP_YUV422_FIR_EN
    hist_vld_d  = hist_vld_q;
    hist_cb_d   = hist_cb_q;
    hist_cr_d   = hist_cr_q;
`endif
    store_even  = 1'b0;

    if (out_xfer_c) o_vld_d = 1'b0;

    case (state_q)
      S_EVEN: begin
        if (in_xfer_c) begin
          store_even = 1'b1;
          state_d    = S_ODD;
        end
      end
      S_ODD: begin
        if (in_xfer_c) begin
          if (bus.i_hstr) begin
            // Line restarted on an unpaired pixel: drop it and flag the error.
            err_d      = 1'b1;
            store_even = 1'b1;
          end else begin
            o_vld_d   = 1'b1;
            o_y_d     = hold_y_q;
            o_c_d     = pair_cb_c;
            o_sel_d   = 1'b0;
            o_hstr_d  = hold_hstr_q;
            hold_y_d  = bus.i_data_y;
            hold_cr_d = pair_cr_c;
`ifdef IP_YUV422_FIR_EN
            hist_vld_d = 1'b1;
            hist_cb_d  = bus.i_data_cb;
            hist_cr_d  = bus.i_data_cr;
`endif
            state_d   = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_xfer_c) begin
          o_vld_d  = 1'b1;
          o_y_d    = hold_y_q;
          o_c_d    = hold_cr_q;
          o_sel_d  = 1'b1;
          o_hstr_d = 1'b0;
          if (in_xfer_c) begin
            store_even = 1'b1;
            state_d    = S_ODD;
          end else begin
            state_d    = S_EVEN;
          end
        end
      end
      default: state_d = S_EVEN;
    endcase

    if (store_even) begin
      hold_y_d    = bus.i_data_y;
      hold_cb_d   = bus.i_data_cb;
      hold_cr_d   = bus.i_data_cr;
      hold_hstr_d = bus.i_hstr;
`ifdef IP_YUV422_FIR_EN
      if (bus.i_hstr) hist_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EVEN;
      hold_y_q    <= '0;
      hold_cb_q   <= '0;
      hold_cr_q   <= '0;
      hold_hstr_q <= 1'b0;
      o_vld_q     <= 1'b0;
      o_hstr_q    <= 1'b0;
      o_y_q       <= '0;
      o_c_q       <= '0;
      o_sel_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef IP_YUV422_FIR_EN
      hist_vld_q  <= 1'b0;
      hist_cb_q   <= '0;
      hist_cr_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_y_q    <= hold_y_d;
      hold_cb_q   <= hold_cb_d;
      hold_cr_q   <= hold_cr_d;
      hold_hstr_q <= hold_hstr_d;
      o_vld_q     <= o_vld_d;
      o_hstr_q    <= o_hstr_d;
      o_y_q       <= o_y_d;
      o_c_q       <= o_c_d;
      o_sel_q     <= o_sel_d;
      err_q       <= err_d;
`ifdef IP_YUV422_FIR_EN
      hist_vld_q  <= hist_vld_d;
      hist_cb_q   <= hist_cb_d;
      hist_cr_q   <= hist_cr_d;
`endif
    end
  end

  assign bus.o_rdy     = rdy_c;
  assign bus.o_vld     = o_vld_q;
  assign bus.o_hstr    = o_hstr_q;
  assign bus.o_data_y  = o_y_q;
  assign bus.o_data_c  = o_c_q;
  assign bus.o_c_sel   = o_sel_q;
  assign bus.o_odd_err = err_q;

endmodule

// File: tb/tb_ip_yuv444to422.sv
// Scoreboard bench for ip_yuv444to422: a pair-level model predicts 4:2:2 words, a monitor checks them.
module tb_ip_yuv444to422;
  localparam int unsigned DAT_SZ = 8;

  typedef struct {
    int y;
    int c;
    bit sel;
    bit hs;
  } word_t;

  logic clk = 1'b0;
  logic rst;

  ip_yuv444to422_if #(.DAT_SZ(DAT_SZ)) bus ();

  ip_yuv444to422 #(.DAT_SZ(DAT_SZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_out = 0;
  int    rdy_mode = 1;
  word_t exp_q[$];

  // Reference model state: pending unpaired pixel, previous odd chroma of the line, error flag.
  bit m_has, m_first, m_hvld, m_err;
  int m_y, m_cb, m_cr, m_hcb, m_hcr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_in(input int y, input int cb, input int cr, input bit hs);
    int pcb, pcr;
    if (hs || !m_has) begin
      if (hs && m_has) m_err = 1'b1;
      if (hs) m_hvld = 1'b0;
      m_has   = 1'b1;
      m_first = hs;
      m_y = y; m_cb = cb; m_cr = cr;
    end else begin
`ifdef IP_YUV422_FIR_EN
      pcb = ((m_hvld ? m_hcb : m_cb) + 2 * m_cb + cb + 2) / 4;
      pcr = ((m_hvld ? m_hcr : m_cr) + 2 * m_cr + cr + 2) / 4;
`else
      pcb = (m_cb + cb + 1) / 2;
      pcr = (m_cr + cr + 1) / 2;
`endif
      exp_q.push_back('{m_y, pcb, 1'b0, m_first});
      exp_q.push_back('{y, pcr, 1'b1, 1'b0});
      m_hcb  = cb;
      m_hcr  = cr;
      m_hvld = 1'b1;
      m_has  = 1'b0;
    end
  endtask

  // Monitor: checks the presented word against the scoreboard head every cycle it is valid.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_has = 1'b0; m_hvld = 1'b0; m_err = 1'b0;
        check("rdy_in_rst", int'(bus.o_rdy), 0);
      end else begin
        check("odd_err", int'(bus.o_odd_err), int'(m_err));
        if (bus.o_vld) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_word: got y=%0d c=%0d sel=%0d expected no word at %0t",
                     bus.o_data_y, bus.o_data_c, bus.o_c_sel, $time);
          end else begin
            w = exp_q[0];
            check("word_y", int'(bus.o_data_y), w.y);
            check("word_c", int'(bus.o_data_c), w.c);
            check("word_sel", int'(bus.o_c_sel), int'(w.sel));
            check("word_hstr", int'(bus.o_hstr), int'(w.hs));
            if (bus.i_rdy) begin
              void'(exp_q.pop_front());
              n_out++;
            end
          end
        end
        if (bus.i_vld && bus.o_rdy)
          model_in(int'(bus.i_data_y), int'(bus.i_data_cb), int'(bus.i_data_cr), bus.i_hstr);
      end
    end
  end

  // Downstream ready: 0 = stalled, 1 = always ready, otherwise random.
  initial begin
    bus.i_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.i_rdy = 1'b0;
        1:       bus.i_rdy = 1'b1;
        default: bus.i_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic idle(input int n);
    bus.i_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int y, input int cb, input int cr, input bit hs, output int cyc);
    bit acc;
    bus.i_vld     = 1'b1;
    bus.i_hstr    = hs;
    bus.i_data_y  = DAT_SZ'(y);
    bus.i_data_cb = DAT_SZ'(cb);
    bus.i_data_cr = DAT_SZ'(cr);
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 200) begin
      @(negedge clk);
      acc = bus.o_rdy;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.i_vld = 1'b0;
    check("send_accept", int'(acc), 1);
  endtask

  task automatic drain();
    int cnt;
    bus.i_vld = 1'b0;
    rdy_mode  = 1;
    cnt = 0;
    while ((exp_q.size() != 0 || bus.o_vld) && cnt < 500) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_done", int'(cnt < 500), 1);
  endtask

  initial begin
    int cyc;
    int base;
    rst           = 1'b1;
    bus.i_vld     = 1'b0;
    bus.i_hstr    = 1'b0;
    bus.i_data_y  = '0;
    bus.i_data_cb = '0;
    bus.i_data_cr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", int'(bus.o_vld), 0);
    check("rst_hstr", int'(bus.o_hstr), 0);
    check("rst_y", int'(bus.o_data_y), 0);
    check("rst_c", int'(bus.o_data_c), 0);
    check("rst_sel", int'(bus.o_c_sel), 0);
    check("rst_err", int'(bus.o_odd_err), 0);
    check("rst_rdy", int'(bus.o_rdy), 0);
    rst = 1'b0;
    idle(2);

    // Single pair: Y0/Cb one cycle after the odd pixel, Y1/Cr on the next cycle.
    send(10, 100, 200, 1'b1, cyc);
    send(20, 101, 50, 1'b0, cyc);
    check("pair_y0_vld", int'(bus.o_vld), 1);
    check("pair_y0", int'(bus.o_data_y), 10);
    check("pair_y0_sel", int'(bus.o_c_sel), 0);
    check("pair_y0_hstr", int'(bus.o_hstr), 1);
`ifndef IP_YUV422_FIR_EN
    check("pair_cb", int'(bus.o_data_c), 101);
`endif
    @(posedge clk);
    #1;
    check("pair_y1_vld", int'(bus.o_vld), 1);
    check("pair_y1", int'(bus.o_data_y), 20);
    check("pair_y1_sel", int'(bus.o_c_sel), 1);
    check("pair_y1_hstr", int'(bus.o_hstr), 0);
`ifndef IP_YUV422_FIR_EN
    check("pair_cr", int'(bus.o_data_c), 125);
`endif
    drain();

    // Back-pressure while Y0 is presented.
    rdy_mode = 0;
    idle(1);
    send(30, 40, 50, 1'b1, cyc);
    send(60, 70, 80, 1'b0, cyc);
    repeat (5) begin
      @(negedge clk);
      check("bp_vld", int'(bus.o_vld), 1);
      check("bp_rdy", int'(bus.o_rdy), 0);
      check("bp_y0", int'(bus.o_data_y), 30);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    check("bp_y1", int'(bus.o_data_y), 60);
    check("bp_y1_sel", int'(bus.o_c_sel), 1);
    drain();

    // Odd-length line followed by a new line.
    rdy_mode = 2;
    send(1, 11, 21, 1'b1, cyc);
    send(2, 12, 22, 1'b0, cyc);
    send(3, 13, 23, 1'b0, cyc);
    send(4, 14, 24, 1'b1, cyc);
    send(5, 15, 25, 1'b0, cyc);
    drain();
    check("odd_line_err", int'(bus.o_odd_err), 1);

    // Chroma step at line start (exercises the filter history when enabled).
    send(1, 0, 9, 1'b1, cyc);
    send(2, 0, 9, 1'b0, cyc);
    send(3, 255, 9, 1'b0, cyc);
    send(4, 255, 9, 1'b0, cyc);
    drain();

    // Reset while Y1 is pending.
    rdy_mode = 0;
    idle(1);
    send(5, 6, 7, 1'b1, cyc);
    send(8, 9, 10, 1'b0, cyc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_emit_vld", int'(bus.o_vld), 0);
    check("rst_emit_err", int'(bus.o_odd_err), 0);
    check("rst_emit_y", int'(bus.o_data_y), 0);
    rst = 1'b0;
    rdy_mode = 1;
    idle(10);

    // Full-rate streaming line.
    base = n_out;
    for (int i = 0; i < 1920; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), (i == 0), cyc);
      if (i > 0) check("stream_rdy", cyc, 1);
    end
    drain();
    check("stream_words", n_out - base, 1920);

    // Random traffic with random line starts, gaps and back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 11) == 0), cyc);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
